// File: rtl/punc_control_pkg.sv
// Shared encodings for the PUnC control unit: FSM states, LC3 opcodes,
// datapath select/ALU codes and the bundled control vector.
package punc_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXECUTE  = 3'd2,
        ST_EXECUTE2 = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RSV8 = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RSVD = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] MEM_W_ADDR_A       = 2'd0;
    localparam logic [1:0] MEM_W_ADDR_B       = 2'd1;
    localparam logic [1:0] MEM_W_ADDR_MEMDATA = 2'd2;
    localparam logic       MEM_W_DATA_RF      = 1'b0;

    localparam logic [1:0] MEM_R_ADDR_PC  = 2'd0;
    localparam logic [1:0] MEM_R_ADDR_A   = 2'd1;
    localparam logic [1:0] MEM_R_ADDR_B   = 2'd2;
    localparam logic [1:0] MEM_R_ADDR_LDI = 2'd3;

    localparam logic RF_R0_SEL_A = 1'b0;
    localparam logic RF_R0_SEL_B = 1'b1;
    localparam logic RF_R1_SEL_A = 1'b0;
    localparam logic RF_R1_SEL_B = 1'b1;

    // RF_W_DATA_A is the PC-relative address (LEA)
    localparam logic [1:0] RF_W_DATA_ALU = 2'd0;
    localparam logic [1:0] RF_W_DATA_MEM = 2'd1;
    localparam logic [1:0] RF_W_DATA_PC  = 2'd2;
    localparam logic [1:0] RF_W_DATA_A   = 2'd3;

    localparam logic RF_W_ADDR_A = 1'b0;
    localparam logic RF_W_ADDR_B = 1'b1;

    localparam logic [1:0] PC_LD_DATA_SEL_A = 2'd0;
    localparam logic [1:0] PC_LD_DATA_SEL_B = 2'd1;
    localparam logic [1:0] PC_LD_DATA_SEL_C = 2'd2;

    localparam logic [2:0] ALU_FN_ADD   = 3'd0;
    localparam logic [2:0] ALU_FN_ADD_I = 3'd1;
    localparam logic [2:0] ALU_FN_AND   = 3'd2;
    localparam logic [2:0] ALU_FN_AND_I = 3'd3;
    localparam logic [2:0] ALU_FN_NOT   = 3'd4;

    localparam logic COND_SEL_ALU = 1'b0;
    localparam logic COND_SEL_RF  = 1'b1;

    typedef struct packed {
        logic       mem_w_en;
        logic [1:0] mem_w_addr_sel;
        logic       mem_w_data_sel;
        logic [1:0] mem_r_addr_sel;
        logic       rf_w_en;
        logic       rf_r0_addr_sel;
        logic       rf_r1_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       ir_ld;
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_ld_data_sel;
        logic [2:0] alu_sel;
        logic       cond_ld;
        logic       cond_ld_data_sel;
        logic       ldi_reg_ld;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic [3:0] opcode(input logic [15:0] ir);
        return ir[15:12];
    endfunction

    function automatic logic br_taken(input logic [15:0] ir, input logic n,
                                      input logic z, input logic p);
        return (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    endfunction

endpackage

// File: rtl/punc_decode.sv
// Combinational EXECUTE-state control vector for the current instruction.
module punc_decode
    import punc_control_pkg::*;
(
    input  logic [15:0] i_ir,
    input  logic        i_n,
    input  logic        i_z,
    input  logic        i_p,
    output ctrl_t       o_ctrl
);

    logic [3:0] w_op;
    logic       w_unused_ir;
    ctrl_t      w_ctrl;

    assign w_op        = opcode(i_ir);
    assign w_unused_ir = ^{i_ir[8:6], i_ir[4:0]};
    assign o_ctrl      = w_ctrl;

    // Per-opcode datapath controls for the EXECUTE cycle
    always_comb begin
        w_ctrl = CTRL_IDLE;
        case (w_op)
            OP_ADD, OP_AND: begin
                w_ctrl.rf_r0_addr_sel = RF_R0_SEL_A;
                if (i_ir[5]) begin
                    w_ctrl.alu_sel = (w_op == OP_ADD) ? ALU_FN_ADD_I : ALU_FN_AND_I;
                end else begin
                    w_ctrl.rf_r1_addr_sel = RF_R1_SEL_A;
                    w_ctrl.alu_sel = (w_op == OP_ADD) ? ALU_FN_ADD : ALU_FN_AND;
                end
                w_ctrl.rf_w_data_sel    = RF_W_DATA_ALU;
                w_ctrl.rf_w_addr_sel    = RF_W_ADDR_A;
                w_ctrl.rf_w_en          = 1'b1;
                w_ctrl.cond_ld          = 1'b1;
                w_ctrl.cond_ld_data_sel = COND_SEL_ALU;
            end
            OP_NOT: begin
                w_ctrl.rf_r0_addr_sel   = RF_R0_SEL_A;
                w_ctrl.alu_sel          = ALU_FN_NOT;
                w_ctrl.rf_w_data_sel    = RF_W_DATA_ALU;
                w_ctrl.rf_w_addr_sel    = RF_W_ADDR_A;
                w_ctrl.rf_w_en          = 1'b1;
                w_ctrl.cond_ld          = 1'b1;
                w_ctrl.cond_ld_data_sel = COND_SEL_ALU;
            end
            OP_BR: begin
                if (br_taken(i_ir, i_n, i_z, i_p)) begin
                    w_ctrl.pc_ld          = 1'b1;
                    w_ctrl.pc_ld_data_sel = PC_LD_DATA_SEL_A;
                end else begin
                    w_ctrl.pc_ld = 1'b0;
                end
            end
            OP_JMP: begin
                w_ctrl.rf_r0_addr_sel = RF_R0_SEL_A;
                w_ctrl.pc_ld          = 1'b1;
                w_ctrl.pc_ld_data_sel = PC_LD_DATA_SEL_B;
            end
            OP_JSR: begin
                // Link and jump commit on the same edge, both from the pre-edge PC
                w_ctrl.rf_w_data_sel = RF_W_DATA_PC;
                w_ctrl.rf_w_addr_sel = RF_W_ADDR_B;
                w_ctrl.rf_w_en       = 1'b1;
                w_ctrl.pc_ld         = 1'b1;
                if (i_ir[11]) begin
                    w_ctrl.pc_ld_data_sel = PC_LD_DATA_SEL_C;
                end else begin
                    w_ctrl.pc_ld_data_sel = PC_LD_DATA_SEL_B;
                    w_ctrl.rf_r0_addr_sel = RF_R0_SEL_A;
                end
            end
            OP_LD, OP_LDR: begin
                w_ctrl.mem_r_addr_sel   = (w_op == OP_LD) ? MEM_R_ADDR_A : MEM_R_ADDR_B;
                w_ctrl.rf_r0_addr_sel   = RF_R0_SEL_A;
                w_ctrl.rf_w_data_sel    = RF_W_DATA_MEM;
                w_ctrl.rf_w_addr_sel    = RF_W_ADDR_A;
                w_ctrl.rf_w_en          = 1'b1;
                w_ctrl.cond_ld          = 1'b1;
                w_ctrl.cond_ld_data_sel = COND_SEL_RF;
            end
            OP_LEA: begin
                w_ctrl.rf_w_data_sel    = RF_W_DATA_A;
                w_ctrl.rf_w_addr_sel    = RF_W_ADDR_A;
                w_ctrl.rf_w_en          = 1'b1;
                w_ctrl.cond_ld          = 1'b1;
                w_ctrl.cond_ld_data_sel = COND_SEL_RF;
            end
            OP_LDI: begin
                w_ctrl.mem_r_addr_sel = MEM_R_ADDR_A;
                w_ctrl.ldi_reg_ld     = 1'b1;
            end
            OP_ST: begin
                w_ctrl.rf_r0_addr_sel = RF_R0_SEL_B;
                w_ctrl.mem_w_data_sel = MEM_W_DATA_RF;
                w_ctrl.mem_w_addr_sel = MEM_W_ADDR_A;
                w_ctrl.mem_w_en       = 1'b1;
            end
            OP_STR: begin
                w_ctrl.rf_r0_addr_sel = RF_R0_SEL_B;
                w_ctrl.rf_r1_addr_sel = RF_R1_SEL_B;
                w_ctrl.mem_w_data_sel = MEM_W_DATA_RF;
                w_ctrl.mem_w_addr_sel = MEM_W_ADDR_B;
                w_ctrl.mem_w_en       = 1'b1;
            end
            OP_STI: begin
                // Pointer read is asynchronous, so the store finishes in one cycle
                w_ctrl.mem_r_addr_sel = MEM_R_ADDR_A;
                w_ctrl.rf_r0_addr_sel = RF_R0_SEL_B;
                w_ctrl.mem_w_addr_sel = MEM_W_ADDR_MEMDATA;
                w_ctrl.mem_w_data_sel = MEM_W_DATA_RF;
                w_ctrl.mem_w_en       = 1'b1;
            end
            default: w_ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/punc_control.sv
// PUnC control FSM: FETCH -> DECODE -> EXECUTE (-> EXECUTE2 for LDI) or HALT,
// with Moore outputs decoded from the state register and ir.
module punc_control
    import punc_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    output logic        mem_w_en,
    output logic [1:0]  mem_w_addr_sel,
    output logic        mem_w_data_sel,
    output logic [1:0]  mem_r_addr_sel,
    output logic        rf_w_en,
    output logic        rf_r0_addr_sel,
    output logic        rf_r1_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_w_addr_sel,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_ld_data_sel,
    output logic [2:0]  alu_sel,
    output logic        cond_ld,
    output logic        cond_ld_data_sel,
    output logic        ldi_reg_ld,
    output logic        halted
);

    state_t     r_state;
    ctrl_t      w_exec_ctrl;
    ctrl_t      w_ctrl;
    logic [3:0] w_op;

    assign w_op = opcode(ir);

    punc_decode u_decode (
        .i_ir   (ir),
        .i_n    (n),
        .i_z    (z),
        .i_p    (p),
        .o_ctrl (w_exec_ctrl)
    );

    // State sequencing; reset abandons whatever instruction is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH:    r_state <= ST_DECODE;
                ST_DECODE:   r_state <= ST_EXECUTE;
                ST_EXECUTE: begin
                    if (w_op == OP_LDI) begin
                        r_state <= ST_EXECUTE2;
                    end else if (w_op == OP_HALT) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_EXECUTE2: r_state <= ST_FETCH;
                ST_HALT:     r_state <= ST_HALT;
                default:     r_state <= ST_FETCH;
            endcase
        end
    end

    // Output decode; rst overrides the state so no write can land during reset
    always_comb begin
        w_ctrl = CTRL_IDLE;
        if (rst) begin
            w_ctrl.pc_clr = 1'b1;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    w_ctrl.mem_r_addr_sel = MEM_R_ADDR_PC;
                    w_ctrl.ir_ld          = 1'b1;
                    w_ctrl.pc_inc         = 1'b1;
                end
                ST_DECODE:  w_ctrl = CTRL_IDLE;
                ST_EXECUTE: w_ctrl = w_exec_ctrl;
                ST_EXECUTE2: begin
                    w_ctrl.mem_r_addr_sel   = MEM_R_ADDR_LDI;
                    w_ctrl.rf_w_data_sel    = RF_W_DATA_MEM;
                    w_ctrl.rf_w_addr_sel    = RF_W_ADDR_A;
                    w_ctrl.rf_w_en          = 1'b1;
                    w_ctrl.cond_ld          = 1'b1;
                    w_ctrl.cond_ld_data_sel = COND_SEL_RF;
                end
                ST_HALT: w_ctrl.halted = 1'b1;
                default: w_ctrl = CTRL_IDLE;
            endcase
        end
    end

    assign mem_w_en         = w_ctrl.mem_w_en;
    assign mem_w_addr_sel   = w_ctrl.mem_w_addr_sel;
    assign mem_w_data_sel   = w_ctrl.mem_w_data_sel;
    assign mem_r_addr_sel   = w_ctrl.mem_r_addr_sel;
    assign rf_w_en          = w_ctrl.rf_w_en;
    assign rf_r0_addr_sel   = w_ctrl.rf_r0_addr_sel;
    assign rf_r1_addr_sel   = w_ctrl.rf_r1_addr_sel;
    assign rf_w_data_sel    = w_ctrl.rf_w_data_sel;
    assign rf_w_addr_sel    = w_ctrl.rf_w_addr_sel;
    assign ir_ld            = w_ctrl.ir_ld;
    assign pc_ld            = w_ctrl.pc_ld;
    assign pc_clr           = w_ctrl.pc_clr;
    assign pc_inc           = w_ctrl.pc_inc;
    assign pc_ld_data_sel   = w_ctrl.pc_ld_data_sel;
    assign alu_sel          = w_ctrl.alu_sel;
    assign cond_ld          = w_ctrl.cond_ld;
    assign cond_ld_data_sel = w_ctrl.cond_ld_data_sel;
    assign ldi_reg_ld       = w_ctrl.ldi_reg_ld;
    assign halted           = w_ctrl.halted;

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: a small LC3 datapath around the DUT runs directed
// programs; every cycle the controls are checked against an instruction-level model.
module tb_punc_control;
    import punc_control_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b1;
    logic [15:0] ir;
    logic        n, z, p;
    logic        mem_w_en, mem_w_data_sel, rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel;
    logic        rf_w_addr_sel, ir_ld, pc_ld, pc_clr, pc_inc, cond_ld, cond_ld_data_sel;
    logic        ldi_reg_ld, halted;
    logic [1:0]  mem_w_addr_sel, mem_r_addr_sel, rf_w_data_sel, pc_ld_data_sel;
    logic [2:0]  alu_sel;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    punc_control dut (
        .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
        .mem_w_en(mem_w_en), .mem_w_addr_sel(mem_w_addr_sel), .mem_w_data_sel(mem_w_data_sel),
        .mem_r_addr_sel(mem_r_addr_sel), .rf_w_en(rf_w_en), .rf_r0_addr_sel(rf_r0_addr_sel),
        .rf_r1_addr_sel(rf_r1_addr_sel), .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel),
        .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_ld_data_sel(pc_ld_data_sel),
        .alu_sel(alu_sel), .cond_ld(cond_ld), .cond_ld_data_sel(cond_ld_data_sel),
        .ldi_reg_ld(ldi_reg_ld), .halted(halted)
    );

    // ---------------- LC3 datapath driven by the DUT ----------------
    logic [15:0] prog [0:255];
    logic [15:0] rf_init [0:7];
    logic [15:0] mem [0:255];
    logic [15:0] rf [0:7];
    logic [15:0] pc, ir_q, ldi_q;
    logic [2:0]  nzp;
    logic [15:0] s5, s6, s9, s11, r0d, r1d, mra, mrd, alu_y, rfwd, mwa, pcld;
    logic [2:0]  rfwa;

    assign ir = ir_q;
    assign {n, z, p} = nzp;

    function automatic logic [2:0] flags_of(input logic [15:0] v);
        if (v[15]) return 3'b100;
        else if (v == 16'h0000) return 3'b010;
        else return 3'b001;
    endfunction

    always_comb begin
        s5  = {{11{ir_q[4]}}, ir_q[4:0]};
        s6  = {{10{ir_q[5]}}, ir_q[5:0]};
        s9  = {{7{ir_q[8]}}, ir_q[8:0]};
        s11 = {{5{ir_q[10]}}, ir_q[10:0]};
        r0d = rf[rf_r0_addr_sel ? ir_q[11:9] : ir_q[8:6]];
        r1d = rf[rf_r1_addr_sel ? ir_q[8:6] : ir_q[2:0]];
        case (mem_r_addr_sel)
            MEM_R_ADDR_PC: mra = pc;
            MEM_R_ADDR_A:  mra = pc + s9;
            MEM_R_ADDR_B:  mra = r0d + s6;
            default:       mra = ldi_q;
        endcase
        mrd = mem[mra[7:0]];
        case (alu_sel)
            ALU_FN_ADD:   alu_y = r0d + r1d;
            ALU_FN_ADD_I: alu_y = r0d + s5;
            ALU_FN_AND:   alu_y = r0d & r1d;
            ALU_FN_AND_I: alu_y = r0d & s5;
            ALU_FN_NOT:   alu_y = ~r0d;
            default:      alu_y = 16'h0000;
        endcase
        case (rf_w_data_sel)
            RF_W_DATA_ALU: rfwd = alu_y;
            RF_W_DATA_MEM: rfwd = mrd;
            RF_W_DATA_PC:  rfwd = pc;
            default:       rfwd = pc + s9;
        endcase
        rfwa = rf_w_addr_sel ? 3'd7 : ir_q[11:9];
        case (mem_w_addr_sel)
            MEM_W_ADDR_A: mwa = pc + s9;
            MEM_W_ADDR_B: mwa = r1d + s6;
            default:      mwa = mrd;
        endcase
        case (pc_ld_data_sel)
            PC_LD_DATA_SEL_A: pcld = pc + s9;
            PC_LD_DATA_SEL_B: pcld = r0d;
            default:          pcld = pc + s11;
        endcase
    end

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
            for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
            ir_q  <= 16'h0000;
            ldi_q <= 16'h0000;
        end else begin
            if (mem_w_en) mem[mwa[7:0]] <= r0d;
            if (rf_w_en) rf[rfwa] <= rfwd;
            if (ir_ld) ir_q <= mrd;
            if (ldi_reg_ld) ldi_q <= mrd;
        end
        if (pc_clr) pc <= 16'h0000;
        else if (pc_ld) pc <= pcld;
        else if (pc_inc) pc <= pc + 16'h0001;
        if (rst) nzp <= 3'b010;
        else if (cond_ld) nzp <= flags_of(cond_ld_data_sel == COND_SEL_RF ? rfwd : alu_y);
    end

    // ---------------- instruction-level reference model ----------------
    // m_step counts cycles inside the current instruction (0 = fetch).
    int   m_step = 0;
    logic m_halt = 1'b0;

    function automatic int insn_cycles(input logic [15:0] insn);
        return (insn[15:12] == OP_LDI) ? 4 : 3;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_step <= 0;
            m_halt <= 1'b0;
        end else if (!m_halt) begin
            if (m_step == 2 && ir_q[15:12] == OP_HALT) begin
                m_halt <= 1'b1;
                m_step <= 0;
            end else if (m_step == insn_cycles(ir_q) - 1) begin
                m_step <= 0;
            end else begin
                m_step <= m_step + 1;
            end
        end
    end

    function automatic void want_rf_write(inout ctrl_t e, inout ctrl_t m, input logic [1:0] src,
                                          input logic dst, input logic cond_src);
        e.rf_w_data_sel = src; m.rf_w_data_sel = 2'b11;
        e.rf_w_addr_sel = dst; m.rf_w_addr_sel = 1'b1;
        e.rf_w_en = 1'b1;
        e.cond_ld = 1'b1;
        e.cond_ld_data_sel = cond_src; m.cond_ld_data_sel = 1'b1;
    endfunction

    function automatic void model_ctrl(input logic rst_v, input int step, input logic halt_v,
                                       input logic [15:0] insn, input logic [2:0] f,
                                       output ctrl_t e, output ctrl_t m);
        logic taken;
        e = '0;
        m = '0;
        m.mem_w_en = 1'b1; m.rf_w_en = 1'b1; m.ir_ld = 1'b1; m.pc_ld = 1'b1; m.pc_clr = 1'b1;
        m.pc_inc = 1'b1; m.cond_ld = 1'b1; m.ldi_reg_ld = 1'b1; m.halted = 1'b1;
        taken = (insn[11] & f[2]) | (insn[10] & f[1]) | (insn[9] & f[0]);
        if (rst_v) begin
            e.pc_clr = 1'b1;
        end else if (halt_v) begin
            e.halted = 1'b1;
        end else if (step == 0) begin
            e.mem_r_addr_sel = MEM_R_ADDR_PC; m.mem_r_addr_sel = 2'b11;
            e.ir_ld = 1'b1; e.pc_inc = 1'b1;
        end else if (step == 3) begin
            e.mem_r_addr_sel = MEM_R_ADDR_LDI; m.mem_r_addr_sel = 2'b11;
            want_rf_write(e, m, RF_W_DATA_MEM, RF_W_ADDR_A, COND_SEL_RF);
        end else if (step == 2) begin
            case (insn[15:12])
                4'b0001, 4'b0101, 4'b1001: begin
                    e.rf_r0_addr_sel = RF_R0_SEL_A; m.rf_r0_addr_sel = 1'b1;
                    m.alu_sel = 3'b111;
                    if (insn[15:12] == 4'b1001) e.alu_sel = ALU_FN_NOT;
                    else if (insn[5]) e.alu_sel = (insn[14]) ? ALU_FN_AND_I : ALU_FN_ADD_I;
                    else begin
                        e.alu_sel = (insn[14]) ? ALU_FN_AND : ALU_FN_ADD;
                        e.rf_r1_addr_sel = RF_R1_SEL_A; m.rf_r1_addr_sel = 1'b1;
                    end
                    want_rf_write(e, m, RF_W_DATA_ALU, RF_W_ADDR_A, COND_SEL_ALU);
                end
                4'b0000: if (taken) begin
                    e.pc_ld = 1'b1; e.pc_ld_data_sel = PC_LD_DATA_SEL_A; m.pc_ld_data_sel = 2'b11;
                end
                4'b1100: begin
                    e.rf_r0_addr_sel = RF_R0_SEL_A; m.rf_r0_addr_sel = 1'b1;
                    e.pc_ld = 1'b1; e.pc_ld_data_sel = PC_LD_DATA_SEL_B; m.pc_ld_data_sel = 2'b11;
                end
                4'b0100: begin
                    e.rf_w_data_sel = RF_W_DATA_PC; m.rf_w_data_sel = 2'b11;
                    e.rf_w_addr_sel = RF_W_ADDR_B; m.rf_w_addr_sel = 1'b1;
                    e.rf_w_en = 1'b1; e.pc_ld = 1'b1; m.pc_ld_data_sel = 2'b11;
                    if (insn[11]) e.pc_ld_data_sel = PC_LD_DATA_SEL_C;
                    else begin
                        e.pc_ld_data_sel = PC_LD_DATA_SEL_B;
                        e.rf_r0_addr_sel = RF_R0_SEL_A; m.rf_r0_addr_sel = 1'b1;
                    end
                end
                4'b0010, 4'b0110: begin
                    e.mem_r_addr_sel = insn[14] ? MEM_R_ADDR_B : MEM_R_ADDR_A; m.mem_r_addr_sel = 2'b11;
                    if (insn[14]) begin e.rf_r0_addr_sel = RF_R0_SEL_A; m.rf_r0_addr_sel = 1'b1; end
                    want_rf_write(e, m, RF_W_DATA_MEM, RF_W_ADDR_A, COND_SEL_RF);
                end
                4'b1110: want_rf_write(e, m, RF_W_DATA_A, RF_W_ADDR_A, COND_SEL_RF);
                4'b1010: begin
                    e.mem_r_addr_sel = MEM_R_ADDR_A; m.mem_r_addr_sel = 2'b11;
                    e.ldi_reg_ld = 1'b1;
                end
                4'b0011, 4'b0111, 4'b1011: begin
                    e.rf_r0_addr_sel = RF_R0_SEL_B; m.rf_r0_addr_sel = 1'b1;
                    e.mem_w_data_sel = MEM_W_DATA_RF; m.mem_w_data_sel = 1'b1;
                    e.mem_w_en = 1'b1; m.mem_w_addr_sel = 2'b11;
                    if (insn[15:12] == 4'b0011) e.mem_w_addr_sel = MEM_W_ADDR_A;
                    else if (insn[15:12] == 4'b0111) begin
                        e.mem_w_addr_sel = MEM_W_ADDR_B;
                        e.rf_r1_addr_sel = RF_R1_SEL_B; m.rf_r1_addr_sel = 1'b1;
                    end else begin
                        e.mem_w_addr_sel = MEM_W_ADDR_MEMDATA;
                        e.mem_r_addr_sel = MEM_R_ADDR_A; m.mem_r_addr_sel = 2'b11;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check_ctrl();
        ctrl_t act, exp_c, msk;
        act = '0;
        act.mem_w_en = mem_w_en; act.mem_w_addr_sel = mem_w_addr_sel;
        act.mem_w_data_sel = mem_w_data_sel; act.mem_r_addr_sel = mem_r_addr_sel;
        act.rf_w_en = rf_w_en; act.rf_r0_addr_sel = rf_r0_addr_sel;
        act.rf_r1_addr_sel = rf_r1_addr_sel; act.rf_w_data_sel = rf_w_data_sel;
        act.rf_w_addr_sel = rf_w_addr_sel; act.ir_ld = ir_ld; act.pc_ld = pc_ld;
        act.pc_clr = pc_clr; act.pc_inc = pc_inc; act.pc_ld_data_sel = pc_ld_data_sel;
        act.alu_sel = alu_sel; act.cond_ld = cond_ld; act.cond_ld_data_sel = cond_ld_data_sel;
        act.ldi_reg_ld = ldi_reg_ld; act.halted = halted;
        model_ctrl(rst, m_step, m_halt, ir_q, nzp, exp_c, msk);
        n_cmp++;
        if ((act & msk) !== (exp_c & msk)) begin
            n_bad++;
            $display("FAIL ctrl t=%0t step=%0d ir=%h got=%h want=%h care=%h",
                     $time, m_step, ir_q, act & msk, exp_c & msk, msk);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic cyc(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check_ctrl();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
        for (int i = 0; i < 8; i++) rf_init[i] = 16'h0000;
    endtask

    task automatic start_prog();
        rst = 1'b1;
        load_req = 1'b1;
        cyc(1);
        load_req = 1'b0;
        cyc(1);
        check16("reset_pc", pc, 16'h0000);
        rst = 1'b0;
    endtask

    // ---------------- directed programs ----------------
    initial begin
        // ADD, BRz not taken / taken, HALT, restart
        clear_prog();
        prog[0] = 16'h1225; prog[1] = 16'h0403; prog[2] = 16'h5020;
        prog[3] = 16'h0403; prog[7] = 16'hF025;
        start_prog();
        cyc(3);
        check16("add_r1", rf[1], 16'h0005);
        check16("add_nzp", {13'h0, nzp}, 16'h0001);
        check16("add_pc", pc, 16'h0001);
        cyc(3);
        check16("brz_not_taken_pc", pc, 16'h0002);
        cyc(3);
        check16("and_r0", rf[0], 16'h0000);
        check16("and_nzp", {13'h0, nzp}, 16'h0002);
        cyc(3);
        check16("brz_taken_pc", pc, 16'h0007);
        cyc(3);
        check16("halt_flag", {15'h0, halted}, 16'h0001);
        check16("halt_pc", pc, 16'h0008);
        cyc(20);
        check16("halt_pc_frozen", pc, 16'h0008);
        check16("halt_flag_held", {15'h0, halted}, 16'h0001);
        rst = 1'b1;
        cyc(1);
        check16("halt_rst_pc", pc, 16'h0000);
        rst = 1'b0;
        cyc(3);
        check16("restart_pc", pc, 16'h0001);

        // LDI R2,#2: 4 cycles, negative result
        clear_prog();
        prog[0] = 16'hA402; prog[3] = 16'h0010; prog[16] = 16'h8000;
        rf_init[2] = 16'h1234;
        start_prog();
        cyc(3);
        check16("ldi_r2_not_yet", rf[2], 16'h1234);
        cyc(1);
        check16("ldi_r2", rf[2], 16'h8000);
        check16("ldi_nzp", {13'h0, nzp}, 16'h0004);
        check16("ldi_pc", pc, 16'h0001);

        // rst in LDI EXECUTE2: no write, back to fetch from 0
        start_prog();
        cyc(3);
        rst = 1'b1;
        cyc(1);
        check16("ldi_abort_r2", rf[2], 16'h1234);
        check16("ldi_abort_pc", pc, 16'h0000);
        rst = 1'b0;
        cyc(4);
        check16("ldi_rerun_r2", rf[2], 16'h8000);

        // JSR #5: link and jump on the same edge
        clear_prog();
        prog[0] = 16'h4805;
        start_prog();
        cyc(3);
        check16("jsr_r7", rf[7], 16'h0001);
        check16("jsr_pc", pc, 16'h0006);

        // ADD, ST, LDR, NOT, HALT
        clear_prog();
        prog[0] = 16'h1225; prog[1] = 16'h3204; prog[2] = 16'h6606;
        prog[3] = 16'h98FF; prog[4] = 16'hF025;
        start_prog();
        cyc(15);
        check16("st_mem6", mem[6], 16'h0005);
        check16("ldr_r3", rf[3], 16'h0005);
        check16("not_r4", rf[4], 16'hFFFA);
        check16("not_nzp", {13'h0, nzp}, 16'h0004);
        check16("prog_e_pc", pc, 16'h0005);

        // STI, reserved opcode, never-taken BR, HALT
        clear_prog();
        prog[0] = 16'hB201; prog[1] = 16'h8000; prog[2] = 16'h0020; prog[3] = 16'hF025;
        rf_init[1] = 16'h00AB;
        start_prog();
        cyc(12);
        check16("sti_mem20", mem[32], 16'h00AB);
        check16("sti_pc", pc, 16'h0004);
        check16("sti_halted", {15'h0, halted}, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
